// File: rtl/alu_ctrl_fsm.sv
// rtl/alu_ctrl_fsm.sv - multicycle control FSM driving the 32-bit datapath and ALU command.
// Optional bne support is enabled by defining ALU_CTRL_BNE_EN.
module alu_ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_Op,
  input  logic [5:0] i_Funct,
  input  logic       zeroflag,
  output logic [2:0] o_Cmd,
  output logic       o_IrWrite,
  output logic       o_MemWrite,
  output logic       o_RegWrite,
  output logic       o_IorD,
  output logic       o_MemToReg,
  output logic       o_RegDst,
  output logic       o_AluSrcA,
  output logic [1:0] o_AluSrcB,
  output logic [1:0] o_PcSrc,
  output logic       o_PcEn,
  output logic [3:0] o_State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef ALU_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] CMD_AND  = 3'b000;
  localparam logic [2:0] CMD_OR   = 3'b001;
  localparam logic [2:0] CMD_ADD  = 3'b010;
  localparam logic [2:0] CMD_SUB  = 3'b110;
  localparam logic [2:0] CMD_SLT  = 3'b111;

  state_t     state;
  state_t     state_next;
  logic       pc_write;
  logic       branch;
  logic       branch_taken;
  logic [2:0] funct_cmd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

`ifdef ALU_CTRL_BNE_EN
  // Captured in DECODE so BRANCH knows which sense of zeroflag takes the branch.
  logic bne;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bne <= 1'b0;
    end else if (state == S_DECODE) begin
      bne <= (i_Op == OP_BNE);
    end
  end

  assign branch_taken = branch & (zeroflag ^ bne);
`else
  assign branch_taken = branch & zeroflag;
`endif

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:   state_next = S_DECODE;
      S_DECODE: begin
        case (i_Op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
`ifdef ALU_CTRL_BNE_EN
          OP_BNE:       state_next = S_BRANCH;
`endif
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (i_Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = S_MEMWB;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Unknown functs still execute as ADD and write back.
  always_comb begin
    funct_cmd = CMD_ADD;
    case (i_Funct)
      6'b100000: funct_cmd = CMD_ADD;
      6'b100010: funct_cmd = CMD_SUB;
      6'b100100: funct_cmd = CMD_AND;
      6'b100101: funct_cmd = CMD_OR;
      6'b101010: funct_cmd = CMD_SLT;
      default:   funct_cmd = CMD_ADD;
    endcase
  end

  always_comb begin
    o_Cmd      = 3'b000;
    o_IrWrite  = 1'b0;
    o_MemWrite = 1'b0;
    o_RegWrite = 1'b0;
    o_IorD     = 1'b0;
    o_MemToReg = 1'b0;
    o_RegDst   = 1'b0;
    o_AluSrcA  = 1'b0;
    o_AluSrcB  = 2'b00;
    o_PcSrc    = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state)
      S_FETCH: begin
        o_IrWrite = 1'b1;
        o_AluSrcB = 2'b01;
        o_PcSrc   = 2'b00;
        pc_write  = 1'b1;
        o_Cmd     = CMD_ADD;
      end
      S_DECODE: begin
        o_AluSrcB = 2'b11;
        o_Cmd     = CMD_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_AluSrcA = 1'b1;
        o_AluSrcB = 2'b10;
        o_Cmd     = CMD_ADD;
      end
      S_MEMRD: begin
        o_IorD = 1'b1;
      end
      S_MEMWB: begin
        o_RegWrite = 1'b1;
        o_MemToReg = 1'b1;
      end
      S_MEMWR: begin
        o_IorD     = 1'b1;
        o_MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        o_AluSrcA = 1'b1;
        o_AluSrcB = 2'b00;
        o_Cmd     = funct_cmd;
      end
      S_ALUWB: begin
        o_RegWrite = 1'b1;
        o_RegDst   = 1'b1;
      end
      S_BRANCH: begin
        o_AluSrcA = 1'b1;
        o_AluSrcB = 2'b00;
        o_PcSrc   = 2'b01;
        o_Cmd     = CMD_SUB;
        branch    = 1'b1;
      end
      S_ADDIWB: begin
        o_RegWrite = 1'b1;
      end
      S_JUMP: begin
        o_PcSrc  = 2'b10;
        pc_write = 1'b1;
      end
      default: begin
        o_Cmd = 3'b000;
      end
    endcase
  end

  assign o_PcEn  = pc_write | branch_taken;
  assign o_State = state;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb/tb_alu_ctrl_fsm.sv - directed self-checking bench for alu_ctrl_fsm.
module tb_alu_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic [5:0] i_Op;
  logic [5:0] i_Funct;
  logic       zeroflag;
  logic [2:0] o_Cmd;
  logic       o_IrWrite, o_MemWrite, o_RegWrite, o_IorD, o_MemToReg, o_RegDst, o_AluSrcA;
  logic [1:0] o_AluSrcB;
  logic [1:0] o_PcSrc;
  logic       o_PcEn;
  logic [3:0] o_State;
  logic [14:0] ctl;

  int total_cnt = 0;
  int pass_cnt  = 0;

  alu_ctrl_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .i_Op       (i_Op),
    .i_Funct    (i_Funct),
    .zeroflag   (zeroflag),
    .o_Cmd      (o_Cmd),
    .o_IrWrite  (o_IrWrite),
    .o_MemWrite (o_MemWrite),
    .o_RegWrite (o_RegWrite),
    .o_IorD     (o_IorD),
    .o_MemToReg (o_MemToReg),
    .o_RegDst   (o_RegDst),
    .o_AluSrcA  (o_AluSrcA),
    .o_AluSrcB  (o_AluSrcB),
    .o_PcSrc    (o_PcSrc),
    .o_PcEn     (o_PcEn),
    .o_State    (o_State)
  );

  // {IrWrite,MemWrite,RegWrite,IorD,MemToReg,RegDst,AluSrcA, AluSrcB, PcSrc, PcEn, Cmd}
  assign ctl = {o_IrWrite, o_MemWrite, o_RegWrite, o_IorD, o_MemToReg, o_RegDst, o_AluSrcA,
                o_AluSrcB, o_PcSrc, o_PcEn, o_Cmd};

  localparam logic [14:0] C_FETCH   = 15'b1000000_01_00_1_010;
  localparam logic [14:0] C_DECODE  = 15'b0000000_11_00_0_010;
  localparam logic [14:0] C_MEMADR  = 15'b0000001_10_00_0_010;
  localparam logic [14:0] C_MEMRD   = 15'b0001000_00_00_0_000;
  localparam logic [14:0] C_MEMWB   = 15'b0010100_00_00_0_000;
  localparam logic [14:0] C_MEMWR   = 15'b0101000_00_00_0_000;
  localparam logic [14:0] C_EX_SLT  = 15'b0000001_00_00_0_111;
  localparam logic [14:0] C_EX_SUB  = 15'b0000001_00_00_0_110;
  localparam logic [14:0] C_EX_OR   = 15'b0000001_00_00_0_001;
  localparam logic [14:0] C_EX_ADD  = 15'b0000001_00_00_0_010;
  localparam logic [14:0] C_ALUWB   = 15'b0010010_00_00_0_000;
  localparam logic [14:0] C_BR_TKN  = 15'b0000001_00_01_1_110;
  localparam logic [14:0] C_BR_NTK  = 15'b0000001_00_01_0_110;
  localparam logic [14:0] C_ADDIWB  = 15'b0010000_00_00_0_000;
  localparam logic [14:0] C_JUMP    = 15'b0000000_00_10_1_000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic at(input string tag, input logic [3:0] st, input logic [14:0] c);
    chk({tag, "_state"}, {12'd0, o_State}, {12'd0, st});
    chk({tag, "_ctl"}, {1'b0, ctl}, {1'b0, c});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    i_Op     = 6'b000000;
    i_Funct  = 6'b100000;
    zeroflag = 1'b0;
    #23;
    at("reset", 4'd0, C_FETCH);

    @(negedge clk);
    rst = 1'b1;
    step();
    at("release", 4'd1, C_DECODE);
    i_Op = 6'b111111;
    step();
    at("illegal_back", 4'd0, C_FETCH);

    // lw: 0,1,2,3,4,0
    i_Op = 6'b100011;
    step(); at("lw_dec", 4'd1, C_DECODE);
    step(); at("lw_adr", 4'd2, C_MEMADR);
    step(); at("lw_rd",  4'd3, C_MEMRD);
    step(); at("lw_wb",  4'd4, C_MEMWB);
    step(); at("lw_end", 4'd0, C_FETCH);

    // sw: 0,1,2,5,0
    i_Op = 6'b101011;
    step(); at("sw_dec", 4'd1, C_DECODE);
    step(); at("sw_adr", 4'd2, C_MEMADR);
    step(); at("sw_wr",  4'd5, C_MEMWR);
    step(); at("sw_end", 4'd0, C_FETCH);

    // R-type with three functs; zeroflag high must not leak into PcEn
    i_Op = 6'b000000;
    zeroflag = 1'b1;
    i_Funct = 6'b101010;
    step(); at("slt_dec", 4'd1, C_DECODE);
    step(); at("slt_ex",  4'd6, C_EX_SLT);
    step(); at("slt_wb",  4'd7, C_ALUWB);
    step(); at("slt_end", 4'd0, C_FETCH);
    i_Funct = 6'b100010;
    step(); step(); at("sub_ex", 4'd6, C_EX_SUB);
    step(); step();
    i_Funct = 6'b100101;
    step(); step(); at("or_ex", 4'd6, C_EX_OR);
    step(); step();
    i_Funct = 6'b111000;
    step(); step(); at("unk_ex", 4'd6, C_EX_ADD);
    step(); at("unk_wb", 4'd7, C_ALUWB);
    step(); at("unk_end", 4'd0, C_FETCH);
    zeroflag = 1'b0;

    // addi: 0,1,9,10,0
    i_Op = 6'b001000;
    step(); at("addi_dec", 4'd1, C_DECODE);
    step(); at("addi_ex",  4'd9, C_MEMADR);
    step(); at("addi_wb",  4'd10, C_ADDIWB);
    step(); at("addi_end", 4'd0, C_FETCH);

    // beq: PcEn follows zeroflag combinationally
    i_Op = 6'b000100;
    step(); at("beq_dec", 4'd1, C_DECODE);
    step(); at("beq_nt", 4'd8, C_BR_NTK);
    zeroflag = 1'b1; #1;
    at("beq_tk", 4'd8, C_BR_TKN);
    zeroflag = 1'b0; #1;
    at("beq_nt2", 4'd8, C_BR_NTK);
    step(); at("beq_end", 4'd0, C_FETCH);

    // j: 0,1,11,0
    i_Op = 6'b000010;
    step(); at("j_dec", 4'd1, C_DECODE);
    step(); at("j_jmp", 4'd11, C_JUMP);
    step(); at("j_end", 4'd0, C_FETCH);

    // 000101: bne when enabled, otherwise illegal
    i_Op = 6'b000101;
    step(); at("bne_dec", 4'd1, C_DECODE);
`ifdef ALU_CTRL_BNE_EN
    step(); at("bne_z0", 4'd8, C_BR_TKN);
    zeroflag = 1'b1; #1;
    at("bne_z1", 4'd8, C_BR_NTK);
    zeroflag = 1'b0;
    step(); at("bne_end", 4'd0, C_FETCH);
`else
    step(); at("bne_illegal", 4'd0, C_FETCH);
`endif

    // reset in the middle of MEMRD
    i_Op = 6'b100011;
    step(); step(); step(); at("rst_pre", 4'd3, C_MEMRD);
    #2 rst = 1'b0;
    #1 at("rst_mid", 4'd0, C_FETCH);
    step(); at("rst_hold", 4'd0, C_FETCH);
    rst = 1'b1;
    step(); at("rst_rel", 4'd1, C_DECODE);
    step(); at("rst_adr", 4'd2, C_MEMADR);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
